// File: rtl/pipelined_carry_adder_if.sv
// Operand/result bus of the pipelined carry adder.
// The producer/consumer side uses the master modport and the adder uses the slave modport.
interface pipelined_carry_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;

    modport master (
        output in_valid, A, B, Cin, Sub, out_ready,
        input  in_ready, out_valid, Sum, Cout, Overflow
    );

    modport slave (
        input  in_valid, A, B, Cin, Sub, out_ready,
        output in_ready, out_valid, Sum, Cout, Overflow
    );
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract unit. The operation is split into STAGES chunks of WIDTH/STAGES bits,
// and each stage registers the carry it produces.
// Operands that have not been used yet travel up the pipe shrinking one chunk per stage.
// Sum chunks that are already finished travel with them growing one chunk per stage.
// A per-stage valid bit forms an elastic pipe: a stage may load when it is empty or when its successor advances.
// WIDTH must be a multiple of STAGES, and STAGES must be at least 1.
module pipelined_carry_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipelined_carry_adder_if.slave  bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic             in_ready_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c_eff_s;

    // Subtraction folds into the adder as A + ~B + ~Cin
    always_comb begin
        if (bus.Sub) begin
            b_eff_s = ~bus.B;
            c_eff_s = ~bus.Cin;
        end else begin
            b_eff_s = bus.B;
            c_eff_s = bus.Cin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unprocessed when entering this stage, and sum bits finished after it
        localparam int REM  = WIDTH - k * CHUNK;
        localparam int DONE = (k + 1) * CHUNK;

        logic            vld_q, vld_d;
        logic            c_q, c_d;
        logic            adv_s;
        logic            src_v_s;
        logic            src_c_s;
        logic [REM-1:0]  src_a_s, src_b_s;
        logic [CHUNK:0]  chunk_s;
        logic [DONE-1:0] new_s_s, s_q, s_d;

        if (k == 0) begin : g_src
            assign src_v_s = bus.in_valid & in_ready_s;
            assign src_a_s = bus.A;
            assign src_b_s = b_eff_s;
            assign src_c_s = c_eff_s;
            assign new_s_s = chunk_s[CHUNK-1:0];
        end else begin : g_src
            assign src_v_s = g_stage[k-1].vld_q;
            assign src_a_s = g_stage[k-1].g_fwd.a_q;
            assign src_b_s = g_stage[k-1].g_fwd.b_q;
            assign src_c_s = g_stage[k-1].c_q;
            assign new_s_s = {chunk_s[CHUNK-1:0], g_stage[k-1].s_q};
        end

        // Stall chain: a stage moves when it is empty or when the stage after it moves
        if (k == STAGES - 1) begin : g_adv
            assign adv_s = ~vld_q | bus.out_ready;
        end else begin : g_adv
            assign adv_s = ~vld_q | g_stage[k+1].adv_s;
        end

        // Chunk adder: the low chunk of the remaining operands plus the incoming carry
        always_comb begin
            chunk_s = {1'b0, src_a_s[CHUNK-1:0]} + {1'b0, src_b_s[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, src_c_s};
        end

        // Stage load/hold: data is taken only with a valid beat, so bubbles never disturb held results
        always_comb begin
            vld_d = vld_q;
            s_d   = s_q;
            c_d   = c_q;
            if (adv_s) begin
                vld_d = src_v_s;
                if (src_v_s) begin
                    s_d = new_s_s;
                    c_d = chunk_s[CHUNK];
                end else begin
                    s_d = s_q;
                    c_d = c_q;
                end
            end else begin
                vld_d = vld_q;
            end
        end

        // Stage state register with synchronous active-low reset
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= {DONE{1'b0}};
            end else begin
                vld_q <= vld_d;
                c_q   <= c_d;
                s_q   <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-CHUNK-1:0] a_q, a_d, b_q, b_d;

            // Skewed operands: pass the upper chunks that are still unused to the next stage
            always_comb begin
                if (adv_s && src_v_s) begin
                    a_d = src_a_s[REM-1:CHUNK];
                    b_d = src_b_s[REM-1:CHUNK];
                end else begin
                    a_d = a_q;
                    b_d = b_q;
                end
            end

            // Skewed operand register
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= {(REM-CHUNK){1'b0}};
                    b_q <= {(REM-CHUNK){1'b0}};
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_ovf
            logic ovf_q, ovf_d;

            // Signed overflow: the operand signs agree but the sign of the sum differs
            always_comb begin
                if (adv_s && src_v_s) begin
                    ovf_d = (src_a_s[CHUNK-1] == src_b_s[CHUNK-1]) &&
                            (chunk_s[CHUNK-1] != src_a_s[CHUNK-1]);
                end else begin
                    ovf_d = ovf_q;
                end
            end

            // Overflow flag register
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign in_ready_s    = rst_n & g_stage[0].adv_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = g_stage[STAGES-1].vld_q;
    assign bus.Sum       = g_stage[STAGES-1].s_q;
    assign bus.Cout      = g_stage[STAGES-1].c_q;
    assign bus.Overflow  = g_stage[STAGES-1].g_ovf.ovf_q;
endmodule
